// File: rtl/l1b_pkg.sv
// Shared types and constants for the L1B bus controller: FSM states,
// the bank that routes to the host bus, and default timing parameters.
package l1b_pkg;

  typedef enum logic [2:0] {
    FLO   = 3'd0,
    FHI   = 3'd1,
    HWAIT = 3'd2,
    HHI   = 3'd3,
    HEND  = 3'd4
  } l1b_state_e;

  localparam logic [7:0] HOST_BANK       = 8'h00;
  localparam int         FAST_HALF_DEF   = 2;
  localparam int         SYNC_STAGES_DEF = 2;
  localparam int         CNT_W           = 3;

  function automatic logic bus_valid(input logic vda, input logic vpa);
    return vda | vpa;
  endfunction

endpackage

// File: rtl/l1b_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, with single-cycle
// rise and fall pulses taken from the last two stages.
module l1b_sync_edge
  import l1b_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign rise_o = sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall_o = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/l1b_bus_ctrl.sv
// CPU clock generator and bus steering: bank 0 accesses stretch into host
// cycles locked to bbc_phi0, other banks run fast against the external SRAM.
module l1b_bus_ctrl
  import l1b_pkg::*;
#(
  parameter int FAST_HALF   = FAST_HALF_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic       hsclk,
  input  logic       resetb,
  input  logic       bbc_phi0,
  input  logic       rdy,
  input  logic       cpu_vda,
  input  logic       cpu_vpa,
  input  logic       cpu_rnw,
  input  logic       cpu_e,
  input  logic [7:0] cpu_d_in,
  output logic       cpu_ck_phi2,
  output logic       lat_en,
  output logic       bbc_rnw,
  output logic       bbc_sync,
  output logic       ram_ceb,
  output logic       ram_web,
  output logic [2:0] ram_a,
  output logic       host_busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FAST_HALF - 1);

  l1b_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [7:0]             bank_q, bank_d;
  logic [SYNC_STAGES-1:0] rdy_sync_q;
  logic                   rdy_s;
  logic                   phi0_rise_s, phi0_fall_s;
  logic                   valid_s, sram_sel_s, host_s;

  logic       phi2_q, phi2_d;
  logic       lat_en_q, lat_en_d;
  logic       bbc_rnw_q, bbc_rnw_d;
  logic       bbc_sync_q, bbc_sync_d;
  logic       ram_ceb_q, ram_ceb_d;
  logic       ram_web_q, ram_web_d;
  logic [2:0] ram_a_q, ram_a_d;
  logic       host_busy_q, host_busy_d;

  l1b_sync_edge #(
    .STAGES(SYNC_STAGES)
  ) u_phi0_sync (
    .clk_i (hsclk),
    .rst_ni(resetb),
    .d_i   (bbc_phi0),
    .rise_o(phi0_rise_s),
    .fall_o(phi0_fall_s)
  );

  // rdy goes through the same depth so it lines up with the phi0 fall pulse.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      rdy_sync_q <= '0;
    end else begin
      rdy_sync_q <= {rdy_sync_q[SYNC_STAGES-2:0], rdy};
    end
  end

  assign rdy_s   = rdy_sync_q[SYNC_STAGES-1];
  assign valid_s = bus_valid(cpu_vda, cpu_vpa);

  // Next state, half-phase counter and bank capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bank_d  = bank_q;
    case (state_q)
      FLO: begin
        if (cnt_q == LAST_CNT) begin
          if (cpu_e) begin
            bank_d = 8'h00;
          end else begin
            bank_d = cpu_d_in;
          end
          if ((bank_d == HOST_BANK) && valid_s) begin
            state_d = HWAIT;
          end else begin
            state_d = FHI;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      FHI: begin
        if (cnt_q == LAST_CNT) begin
          state_d = FLO;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HWAIT: begin
        if (phi0_rise_s) begin
          state_d = HHI;
        end else begin
          state_d = HWAIT;
        end
      end
      HHI: begin
        if (phi0_fall_s && rdy_s) begin
          state_d = HEND;
        end else begin
          state_d = HHI;
        end
      end
      HEND:    state_d = FLO;
      default: state_d = FLO;
    endcase
  end

  // Output values for the coming cycle, decoded from the next state so the
  // registered outputs line up with the registered state.
  always_comb begin
    host_s     = (state_d == HWAIT) || (state_d == HHI);
    sram_sel_s = (state_d == FHI) && valid_s && (bank_d != HOST_BANK);

    phi2_d      = (state_d == FHI) || (state_d == HHI);
    lat_en_d    = (state_d == HWAIT);
    host_busy_d = host_s;
    ram_ceb_d   = ~sram_sel_s;

    if (state_d == HHI) begin
      bbc_rnw_d = cpu_rnw;
    end else begin
      bbc_rnw_d = 1'b1;
    end

    if (host_s) begin
      bbc_sync_d = cpu_vda & cpu_vpa;
    end else begin
      bbc_sync_d = 1'b0;
    end

    if (sram_sel_s) begin
      ram_a_d = bank_d[2:0];
    end else begin
      ram_a_d = 3'd0;
    end

    // The first FHI cycle lets the address settle before the write strobe.
    if (sram_sel_s && !cpu_rnw && (cnt_d != '0)) begin
      ram_web_d = 1'b0;
    end else begin
      ram_web_d = 1'b1;
    end
  end

  // State, counter, bank and output registers.
  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= FLO;
      cnt_q       <= '0;
      bank_q      <= 8'h00;
      phi2_q      <= 1'b0;
      lat_en_q    <= 1'b0;
      bbc_rnw_q   <= 1'b1;
      bbc_sync_q  <= 1'b0;
      ram_ceb_q   <= 1'b1;
      ram_web_q   <= 1'b1;
      ram_a_q     <= 3'd0;
      host_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      phi2_q      <= phi2_d;
      lat_en_q    <= lat_en_d;
      bbc_rnw_q   <= bbc_rnw_d;
      bbc_sync_q  <= bbc_sync_d;
      ram_ceb_q   <= ram_ceb_d;
      ram_web_q   <= ram_web_d;
      ram_a_q     <= ram_a_d;
      host_busy_q <= host_busy_d;
    end
  end

  assign cpu_ck_phi2 = phi2_q;
  assign lat_en      = lat_en_q;
  assign bbc_rnw     = bbc_rnw_q;
  assign bbc_sync    = bbc_sync_q;
  assign ram_ceb     = ram_ceb_q;
  assign ram_web     = ram_web_q;
  assign ram_a       = ram_a_q;
  assign host_busy   = host_busy_q;

endmodule

// File: doc/l1b_bus_ctrl.md
L1B_BUS_CTRL -- requirements
Module: l1b_bus_ctrl

Interface
REQ-001 Parameter FAST_HALF, default 2: hsclk cycles per half-phase of the fast CPU clock (legal range 1..8).
REQ-002 Parameter SYNC_STAGES, default 2: number of flops in the bbc_phi0 synchroniser (legal range 2..3).
REQ-003 The block SHALL have one clock, hsclk, and an asynchronous active-low reset, resetb.
REQ-004 Ports SHALL be exactly as listed; all outputs SHALL be registered:
- hsclk  in  1  system clock from the oscillator
- resetb  in  1  asynchronous active-low reset
- bbc_phi0  in  1  host clock, asynchronous to hsclk
- rdy  in  1  host ready; low stretches a host cycle
- cpu_vda  in  1  CPU valid data address
- cpu_vpa  in  1  CPU valid program address
- cpu_rnw  in  1  CPU read/not-write
- cpu_e  in  1  CPU emulation flag
- cpu_d_in  in  8  CPU data bus sample; carries the bank byte while phi2 is low
- cpu_ck_phi2  out  1  CPU clock
- lat_en  out  1  enable for the host address latch
- bbc_rnw  out  1  host read/not-write
- bbc_sync  out  1  host SYNC; equals cpu_vda&cpu_vpa during host cycles, else 0
- ram_ceb  out  1  SRAM chip/output enable, active-low
- ram_web  out  1  SRAM write enable, active-low
- ram_a  out  3  SRAM address bits 18:16
- host_busy  out  1  high while a host cycle is in progress

Function
REQ-005 The FSM SHALL have exactly these states: FLO, FHI, HWAIT, HHI, HEND.
REQ-006 FLO: cpu_ck_phi2=0 for FAST_HALF hsclk cycles. In the last of these cycles the bank register SHALL load cpu_d_in, or 0 when cpu_e=1.
REQ-007 At the end of FLO, decode the cycle:
- bank==0 and (cpu_vda|cpu_vpa)=1: host cycle, go to HWAIT.
- otherwise: fast cycle, go to FHI.
REQ-008 FHI: cpu_ck_phi2=1 for FAST_HALF cycles, then go to FLO.
- For a valid cycle in a bank other than 0: ram_ceb=0 and ram_a=bank[2:0].
- ram_web=0 only when cpu_rnw=0, and only for cycles 2..FAST_HALF of FHI.
- With FAST_HALF=1, ram_web SHALL stay 1 (writes unsupported; documented limitation).
REQ-009 An internal cycle (cpu_vda=cpu_vpa=0) SHALL never touch SRAM or host: it runs fast, with ram_ceb=1 and ram_web=1.
REQ-010 Banks 8..255 alias onto bank[2:0], so bank 0x09 maps to ram_a=1.
REQ-011 HWAIT: cpu_ck_phi2 held 0, lat_en=1, host_busy=1. Leave for HHI on the first synchronised rising edge of bbc_phi0.
REQ-012 HHI: cpu_ck_phi2=1, bbc_rnw=cpu_rnw, host_busy=1.
- On a synchronised falling edge of bbc_phi0 with rdy=1 (sampled through the same synchroniser depth), go to HEND.
- With rdy=0, stay in HHI for further host cycles.
REQ-013 HEND: one hsclk cycle with cpu_ck_phi2=0, lat_en=0, bbc_rnw=1, host_busy=0, then go to FLO. FLO then runs its full FAST_HALF count.
REQ-014 Outside HWAIT, lat_en SHALL be 0. Outside HHI, bbc_rnw SHALL be 1.
REQ-015 Edge detection SHALL compare the last two synchroniser stages. An edge present on the same cycle the FSM enters HWAIT SHALL be honoured.
REQ-016 A host cycle SHALL have no timeout: rdy held low holds the CPU indefinitely.
REQ-017 ram_ceb and ram_web SHALL never both be 0 while cpu_ck_phi2=0.

Reset
REQ-018 While resetb=0, outputs SHALL be asynchronously forced to:
- state FLO, half-phase counter 0, bank 0, synchroniser flops 0
- cpu_ck_phi2=0, lat_en=0, bbc_rnw=1, bbc_sync=0, ram_ceb=1, ram_web=1, ram_a=0, host_busy=0
REQ-019 Reset asserted mid host cycle or mid SRAM write SHALL abort it immediately, with no further ram_web pulse.
REQ-020 After resetb deasserts, the first cpu_ck_phi2 rising edge SHALL occur no earlier than FAST_HALF hsclk cycles later.

Structure
REQ-021 Package l1b_pkg SHALL hold:
- the state enum type
- constant HOST_BANK=8'h00
- default values of FAST_HALF and SYNC_STAGES
REQ-022 One sub-module, l1b_sync_edge, SHALL implement the parameterised synchroniser with rise and fall pulse outputs. All other logic stays flat in l1b_bus_ctrl.

Verification
REQ-023 Fast SRAM write, with FAST_HALF=2, bank 0x03, vda=1, rnw=0:
- cpu_ck_phi2 period is 4 hsclk cycles
- ram_a=3, ram_ceb=0 for 2 cycles, ram_web=0 for exactly 1 cycle
REQ-024 Host read, with bank 0, vda=1, rnw=1, bbc_phi0 at hsclk/16:
- lat_en high until the synchronised rise of bbc_phi0
- cpu_ck_phi2 high exactly through host phi2 (delayed by SYNC_STAGES)
- host_busy falls one cycle before FLO
REQ-025 Host cycle with rdy=0 for 3 bbc_phi0 periods, then rdy=1: HHI is held across all 3 periods, and HEND is entered on the following synchronised fall.
REQ-026 Internal cycle (vda=vpa=0) in bank 0, then emulation mode (cpu_e=1) with cpu_d_in=0x05 and vda=1:
- the first cycle stays fast with ram_ceb=1
- the second is a host cycle (bank forced to 0)
REQ-027 resetb pulsed low during HHI: all outputs reach their reset values within the same cycle, and a normal fast cycle sequence resumes after release.
REQ-028 Random host/SRAM mix over 10k cycles with assertions on REQ-014 and REQ-017: zero violations.
